decode_split_stage: RTL and testbench
=====================================

// Module: decode_split_stage
// PURPOSE
//  Registered successor to the decode field splitter. Accepts fetched instructions over a
//  valid/ready handshake and splits each into RISC-V fields plus a sign-extended immediate
//  and format code. Results are buffered in a DEPTH-entry FIFO feeding the register-read stage.
//  Sits between fetch and register read in pipeline5; flushed on redirect.
// PARAMETERS
//  XLEN   32  datapath width for pc and immediate (32 or 64)
//  DEPTH  2   FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1          clock, rising edge
//  reset        in   1          asynchronous, active-high reset
//  flush        in   1          synchronous discard of all buffered entries
//  in_valid     in   1          fetch offers in_instr/in_pc
//  in_ready     out  1          stage can accept this cycle
//  in_instr     in   32         raw instruction
//  in_pc        in   XLEN       instruction address
//  out_valid    out  1          head entry valid
//  out_ready    in   1          consumer takes head entry
//  out_pc       out  XLEN       pc of head entry
//  out_opcode   out  7          instr[6:0]
//  out_rd       out  5          instr[11:7]
//  out_funct3   out  3          instr[14:12]
//  out_rs1      out  5          instr[19:15]
//  out_rs2      out  5          instr[24:20]
//  out_funct7_5 out  1          instr[30]
//  out_imm      out  XLEN       sign-extended immediate for the decoded format
//  out_fmt      out  3          0=R 1=I 2=S 3=B 4=U 5=J
//  out_illegal  out  1          opcode not recognised or instr[1:0] != 2'b11
//  out_count    out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset: count, pointers, all storage cleared; out_valid=0, in_ready=1, all out_* fields 0.
//  - Decode happens at write time; stored fields are registered. Head fields drive outputs
//    directly, with no combinational path from in_* to out_*.
//  - Push = in_valid & in_ready; pop = out_valid & out_ready. Latency: entry accepted at
//    edge N is visible with out_valid=1 after edge N (one cycle).
//  - in_ready = (count < DEPTH). It depends only on registered state, not on out_ready.
//    Full: no push, even if a pop happens in the same cycle.
//  - out_valid = (count != 0). Empty: out_* hold the last head contents; consumers must
//    ignore them.
//  - Push and pop in the same cycle (not full, not empty): count unchanged, FIFO order kept.
//  - Read/write pointers wrap modulo DEPTH.
//  - flush: takes priority over push/pop in its cycle. Clears count and pointers; the input
//    offered that cycle is dropped. out_valid=0 the next cycle. Storage is not cleared.
//  - reset asserted mid-operation clears immediately, whatever the handshake state.
//  - Format from opcode[6:2]:
//    - I: 00000 LOAD, 00011 MISC-MEM, 00100 OP-IMM, 11001 JALR, 11100 SYSTEM
//    - S: 01000; B: 11000; U: 01101 LUI, 00101 AUIPC; J: 11011; R: 01100
//    - Anything else: fmt=R, out_illegal=1.
//  - Immediates, sign bit instr[31] extended to XLEN:
//    - I = instr[31:20]; S = {instr[31:25], instr[11:7]}
//    - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
//    - U = {instr[31:12], 12'b0}
//    - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
//    - R: imm = 0.
//  - Illegal instructions are still buffered and passed on; no stall is raised.
// TESTING
//  - addi x1,x2,-1 (0xFFF10093) -> rd=1 rs1=2 fmt=1 imm=0xFFFFFFFF illegal=0, out_valid
//    one cycle after accept.
//  - sw x1,8(x2) (0x00112423) -> fmt=2 imm=8. beq x0,x0,-4 (0xFE000EE3) -> fmt=3
//    imm=0xFFFFFFFC. lui x5,0x12345 (0x123452B7) -> fmt=4 imm=0x12345000.
//  - DEPTH=2, out_ready=0, offer 3 instrs -> in_ready low after 2 accepts, third held.
//    Raise out_ready -> all 3 emerge in order, count returns to 0.
//  - Continuous push and pop at count=1 for 16 cycles -> count stays 1, pointers wrap,
//    no entries lost or duplicated.
//  - flush with count=2 and in_valid=1 in the same cycle -> next cycle count=0,
//    out_valid=0, flushed input absent.
//  - Reset asserted mid-stream between clock edges -> outputs 0 immediately.
//    Instruction 0x0000007F -> illegal=1, fmt=0.

Source files
------------

// File: rtl/decode_split_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_split_stage
// Purpose  : Registered decode stage between fetch and register read. Accepts
//            instructions over a valid/ready handshake and splits each one
//            into its RISC-V fields, a sign-extended immediate and a format
//            code. Decoded results are buffered in a DEPTH-entry FIFO.
// Ports    : clk          - clock, rising edge
//            reset        - asynchronous active-high reset
//            flush        - synchronous discard of all buffered entries
//            in_valid/in_ready/in_instr/in_pc   - fetch side handshake
//            out_valid/out_ready                - consumer side handshake
//            out_pc/opcode/rd/funct3/rs1/rs2/funct7_5/imm/fmt/illegal
//                         - decoded fields of the head entry
//            out_count    - number of entries held
// Revision : 1.0 - initial release
// ============================================================================
module decode_split_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [XLEN-1:0]         in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [6:0]              out_opcode,
    output logic [4:0]              out_rd,
    output logic [2:0]              out_funct3,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic                    out_funct7_5,
    output logic [XLEN-1:0]         out_imm,
    output logic [2:0]              out_fmt,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  out_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            funct7_5;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    // Index of the most recent head, so outputs hold steady while empty.
    logic [PW-1:0]   last_q;
    logic [PW-1:0]   head_idx;

    entry_t          dec;
    fmt_e            fmt;
    logic            known;
    logic [31:0]     imm32;
    logic            push;
    logic            pop;

    // ------------------------------------------------------------------
    // Decode of the offered instruction (written into the FIFO on push)
    // ------------------------------------------------------------------
    always_comb begin
        fmt   = FMT_R;
        known = 1'b1;
        imm32 = 32'd0;
        dec   = '0;

        case (in_instr[6:2])
            5'b00000, 5'b00011, 5'b00100,
            5'b11001, 5'b11100:           fmt = FMT_I;
            5'b01000:                     fmt = FMT_S;
            5'b11000:                     fmt = FMT_B;
            5'b01101, 5'b00101:           fmt = FMT_U;
            5'b11011:                     fmt = FMT_J;
            5'b01100:                     fmt = FMT_R;
            default: begin
                fmt   = FMT_R;
                known = 1'b0;
            end
        endcase

        // All formats place the sign bit at instr[31]; build a 32-bit value
        // and sign-extend it to XLEN afterwards.
        case (fmt)
            FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                              in_instr[11:8], 1'b0};
            FMT_U:   imm32 = {in_instr[31:12], 12'd0};
            FMT_J:   imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                              in_instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase

        dec.pc       = in_pc;
        dec.opcode   = in_instr[6:0];
        dec.rd       = in_instr[11:7];
        dec.funct3   = in_instr[14:12];
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.funct7_5 = in_instr[30];
        dec.imm      = XLEN'($signed(imm32));
        dec.fmt      = fmt;
        dec.illegal  = ~known | (in_instr[1:0] != 2'b11);
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign in_ready  = (count_q < C_DEPTH);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow wraps naturally.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (count_q != '0) begin
                last_q <= rd_ptr_q;
            end
            // Storage is left untouched by flush; only the pointers move.
            if (push && !flush) begin
                mem_q[wr_ptr_q] <= dec;
            end
        end
    end

    // ------------------------------------------------------------------
    // Head entry drives the outputs directly from storage
    // ------------------------------------------------------------------
    assign head_idx     = out_valid ? rd_ptr_q : last_q;
    assign out_pc       = mem_q[head_idx].pc;
    assign out_opcode   = mem_q[head_idx].opcode;
    assign out_rd       = mem_q[head_idx].rd;
    assign out_funct3   = mem_q[head_idx].funct3;
    assign out_rs1      = mem_q[head_idx].rs1;
    assign out_rs2      = mem_q[head_idx].rs2;
    assign out_funct7_5 = mem_q[head_idx].funct7_5;
    assign out_imm      = mem_q[head_idx].imm;
    assign out_fmt      = mem_q[head_idx].fmt;
    assign out_illegal  = mem_q[head_idx].illegal;
    assign out_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_split_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_split_stage
// Purpose  : Self-checking bench for decode_split_stage with a scoreboard
//            queue filled by the driver and drained by an output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_split_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [6:0]        out_opcode;
    logic [4:0]        out_rd;
    logic [2:0]        out_funct3;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic              out_funct7_5;
    logic [XLEN-1:0]   out_imm;
    logic [2:0]        out_fmt;
    logic              out_illegal;
    logic [$clog2(DEPTH):0] out_count;

    decode_split_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_rd       (out_rd),
        .out_funct3   (out_funct3),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_funct7_5 (out_funct7_5),
        .out_imm      (out_imm),
        .out_fmt      (out_fmt),
        .out_illegal  (out_illegal),
        .out_count    (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [2:0] fmt,
                                input logic [31:0] imm, input logic ill);
        exp_t e;
        e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.funct3 = f3; e.fmt = fmt; e.imm = imm; e.ill = ill;
        return e;
    endfunction

    // Offer one instruction; returns at posedge+1 after it is accepted.
    task automatic send(input logic [31:0] instr, input exp_t e);
        int t = 0;
        in_instr = instr;
        in_pc    = e.pc;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            t++;
            if (t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, pc 0x%0h", t, e.pc);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_empty();
        int t = 0;
        while (out_count != 0 || sb.size() != 0) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: count %0d, %0d expected entries left", out_count, sb.size());
                sb.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a pop happens at the next posedge, so compare the head now.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output_sb_size", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_pc",      out_pc,      e.pc);
                check("out_rd",      out_rd,      e.rd);
                check("out_rs1",     out_rs1,     e.rs1);
                check("out_rs2",     out_rs2,     e.rs2);
                check("out_funct3",  out_funct3,  e.funct3);
                check("out_fmt",     out_fmt,     e.fmt);
                check("out_imm",     out_imm,     e.imm);
                check("out_illegal", out_illegal, e.ill);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] I_ADDI  = 32'hFFF10093;
    localparam logic [31:0] I_SW    = 32'h00112423;
    localparam logic [31:0] I_BEQ   = 32'hFE000EE3;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_AUIPC = 32'hFFFFF297;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = 32'd0;
        in_pc     = '0;

        // Reset state
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_count",     out_count, 0);
        check("rst_out_imm",   out_imm,   0);
        check("rst_out_pc",    out_pc,    0);
        check("rst_out_fmt",   out_fmt,   0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // One-cycle latency: addi held with out_ready low
        send(I_ADDI, mk(32'h100, 5'd1, 5'd2, 5'd31, 3'd0, 3'd1, 32'hFFFFFFFF, 1'b0));
        check("lat_out_valid", out_valid, 1'b1);
        check("lat_count",     out_count, 1);
        out_ready = 1'b1;
        wait_empty();

        // One of each format plus an illegal opcode, streaming
        send(I_SW,    mk(32'h104, 5'd8,  5'd2,  5'd1,  3'd2, 3'd2, 32'h00000008, 1'b0));
        send(I_BEQ,   mk(32'h108, 5'd29, 5'd0,  5'd0,  3'd0, 3'd3, 32'hFFFFFFFC, 1'b0));
        send(I_LUI,   mk(32'h10C, 5'd5,  5'd8,  5'd3,  3'd5, 3'd4, 32'h12345000, 1'b0));
        send(I_JAL,   mk(32'h110, 5'd1,  5'd0,  5'd8,  3'd0, 3'd5, 32'h00000008, 1'b0));
        send(I_ADD,   mk(32'h114, 5'd3,  5'd1,  5'd2,  3'd0, 3'd0, 32'h00000000, 1'b0));
        send(I_AUIPC, mk(32'h118, 5'd5,  5'd31, 5'd31, 3'd7, 3'd4, 32'hFFFFF000, 1'b0));
        send(I_BAD,   mk(32'h11C, 5'd0,  5'd0,  5'd0,  3'd0, 3'd0, 32'h00000000, 1'b1));
        wait_empty();

        // Full FIFO: third instruction held until the consumer drains
        out_ready = 1'b0;
        send(I_ADD, mk(32'h200, 5'd3, 5'd1, 5'd2, 3'd0, 3'd0, 32'd0, 1'b0));
        send(I_ADD, mk(32'h204, 5'd3, 5'd1, 5'd2, 3'd0, 3'd0, 32'd0, 1'b0));
        check("full_count",    out_count, 2);
        check("full_in_ready", in_ready,  1'b0);
        fork
            send(I_ADD, mk(32'h208, 5'd3, 5'd1, 5'd2, 3'd0, 3'd0, 32'd0, 1'b0));
            begin
                repeat (3) @(posedge clk);
                #1;
                check("held_in_ready",  in_ready,  1'b0);
                check("held_count",     out_count, 2);
                check("held_out_valid", out_valid, 1'b1);
                out_ready = 1'b1;
            end
        join
        wait_empty();
        check("drain_count", out_count, 0);

        // Continuous push and pop at count=1
        for (int i = 0; i < 17; i++) begin
            send(I_ADDI, mk(32'h300 + 32'(4 * i), 5'd1, 5'd2, 5'd31, 3'd0, 3'd1, 32'hFFFFFFFF, 1'b0));
            check("stream_count", out_count, 1);
        end
        wait_empty();

        // Flush at count=2 with an input offered
        out_ready = 1'b0;
        send(I_SW,  mk(32'h400, 5'd8,  5'd2, 5'd1, 3'd2, 3'd2, 32'h8, 1'b0));
        send(I_BEQ, mk(32'h404, 5'd29, 5'd0, 5'd0, 3'd0, 3'd3, 32'hFFFFFFFC, 1'b0));
        in_instr = I_LUI;
        in_pc    = 32'h408;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush2_count",     out_count, 0);
        check("flush2_out_valid", out_valid, 1'b0);
        check("flush2_in_ready",  in_ready,  1'b1);

        // Flush at count=1 while the input would have been accepted
        send(I_SW, mk(32'h410, 5'd8, 5'd2, 5'd1, 3'd2, 3'd2, 32'h8, 1'b0));
        in_instr = I_JAL;
        in_pc    = 32'h4FF;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush1_count",     out_count, 0);
        check("flush1_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        send(I_ADD, mk(32'h500, 5'd3, 5'd1, 5'd2, 3'd0, 3'd0, 32'd0, 1'b0));
        wait_empty();

        // Asynchronous reset between clock edges
        out_ready = 1'b0;
        send(I_LUI, mk(32'h600, 5'd5, 5'd8, 5'd3, 3'd5, 3'd4, 32'h12345000, 1'b0));
        send(I_SW,  mk(32'h604, 5'd8, 5'd2, 5'd1, 3'd2, 3'd2, 32'h8, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_count",     out_count, 0);
        check("arst_in_ready",  in_ready,  1'b1);
        check("arst_out_pc",    out_pc,    0);
        check("arst_out_imm",   out_imm,   0);
        check("arst_out_rd",    out_rd,    0);
        sb.delete();
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // Illegal opcode after reset
        out_ready = 1'b1;
        send(I_BAD, mk(32'h700, 5'd0, 5'd0, 5'd0, 3'd0, 3'd0, 32'd0, 1'b1));
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
